// File: rtl/sensor_conditioner_if.sv
// Bundle between the loop-detector front end and the traffic light controller.
// It carries raw detector levels and served flags in, and conditioned requests and stuck flags out.
interface sensor_conditioner_if;
  logic [4:0] raw_sensor;
  logic [4:0] lane_green;
  logic       e_str_sensor;
  logic       w_str_sensor;
  logic       e_left_sensor;
  logic       w_left_sensor;
  logic       ns_sensor;
  logic [4:0] stuck;

  modport master (
    output raw_sensor, lane_green,
    input  e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor, stuck
  );

  modport slave (
    input  raw_sensor, lane_green,
    output e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor, stuck
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Five independent loop-detector channels: synchronize, debounce, latch until served,
// hold through short gaps while green, and flag detectors that stay high too long.
module sensor_conditioner #(
  parameter int DEBOUNCE = 3,
  parameter int HOLD     = 2,
  parameter int STUCK    = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  sensor_conditioner_if.slave  bus_io
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUAL,
    ST_LATCHED,
    ST_SERVE,
    ST_STUCK
  } lane_state_e;

  localparam logic [3:0] DEB_M1  = 4'(DEBOUNCE - 1);
  localparam logic [3:0] HOLD_C  = 4'(HOLD);
  localparam logic [7:0] STUCK_C = 8'(STUCK);

  logic [4:0] sync1_q, sync2_q;
  logic [4:0] sens_w, stuck_w;

  // NOTE: reset is synchronous here, so it sits inside the clocked branch, not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus_io.raw_sensor;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_lane
    lane_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  run_q, run_d;
    logic        sens_q, stuck_q;
    logic        s;
    logic        green;

    assign s     = sync2_q[i];
    assign green = bus_io.lane_green[i];

    // NOTE: every next-state value gets a default first so no path can infer a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      run_d   = s ? ((run_q == 8'hFF) ? run_q : run_q + 8'd1) : 8'd0;

      // The stuck detector overrides every normal transition in the same cycle.
      if (s && (run_d >= STUCK_C)) begin
        state_d = ST_STUCK;
        cnt_d   = 4'd0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            cnt_d = 4'd0;
            if (s) begin
              if (DEBOUNCE == 1) begin
                state_d = ST_LATCHED;
              end else begin
                state_d = ST_QUAL;
                cnt_d   = 4'd1;
              end
            end
          end
          ST_QUAL: begin
            if (!s) begin
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end else if (cnt_q == DEB_M1) begin
              state_d = ST_LATCHED;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          ST_LATCHED: begin
            if (green) begin
              state_d = ST_SERVE;
              cnt_d   = 4'd0;
            end
          end
          ST_SERVE: begin
            if (!green) begin
              state_d = s ? ST_LATCHED : ST_IDLE;
              cnt_d   = 4'd0;
            end else if (s) begin
              cnt_d = 4'd0;
            end else if (cnt_q == HOLD_C) begin
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
          ST_STUCK: begin
            if (!s) begin
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= 4'd0;
        run_q   <= 8'd0;
        sens_q  <= 1'b0;
        stuck_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        run_q   <= run_d;
        sens_q  <= (state_d == ST_LATCHED) || (state_d == ST_SERVE);
        stuck_q <= (state_d == ST_STUCK);
      end
    end

    assign sens_w[i]  = sens_q;
    assign stuck_w[i] = stuck_q;
  end

  assign bus_io.e_str_sensor  = sens_w[0];
  assign bus_io.w_str_sensor  = sens_w[1];
  assign bus_io.e_left_sensor = sens_w[2];
  assign bus_io.w_left_sensor = sens_w[3];
  assign bus_io.ns_sensor     = sens_w[4];
  assign bus_io.stuck         = stuck_w;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner: a per-cycle vector table for debounce/serve
// behaviour, then hand-written sequences for the stuck detector and reset recovery.
module tb_sensor_conditioner;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  sensor_conditioner_if bus ();

  sensor_conditioner #(
    .DEBOUNCE (3),
    .HOLD     (2),
    .STUCK    (200)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] raw;
    logic [4:0] green;
    logic [4:0] exp_sens;
    logic [4:0] exp_stuck;
  } vec_t;

  vec_t vecs [19];

  function automatic logic [4:0] sens_vec();
    return {bus.ns_sensor, bus.w_left_sensor, bus.e_left_sensor,
            bus.w_str_sensor, bus.e_str_sensor};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, take the edge, then settle before sampling.
  task automatic tick(input logic [4:0] raw, input logic [4:0] green, input logic rst);
    bus.raw_sensor = raw;
    bus.lane_green = green;
    reset          = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    bus.raw_sensor = '0;
    bus.lane_green = '0;

    // Row r is applied before edge r; expectations are the outputs after that edge.
    // Lane 0 glitch, lane 1 latched then served with raw low, lane 3 served with raw
    // high then green dropped, lane 4 latency/keep, then served and dropped with raw low.
    vecs[0]  = '{1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    vecs[1]  = '{1'b0, 5'b11011, 5'b00000, 5'b00000, 5'b00000};
    vecs[2]  = '{1'b0, 5'b11010, 5'b00000, 5'b00000, 5'b00000};
    vecs[3]  = '{1'b0, 5'b11010, 5'b00000, 5'b00000, 5'b00000};
    vecs[4]  = '{1'b0, 5'b11010, 5'b00000, 5'b00000, 5'b00000};
    vecs[5]  = '{1'b0, 5'b11010, 5'b00000, 5'b11010, 5'b00000};
    vecs[6]  = '{1'b0, 5'b11000, 5'b00000, 5'b11010, 5'b00000};
    vecs[7]  = '{1'b0, 5'b11000, 5'b01000, 5'b11010, 5'b00000};
    vecs[8]  = '{1'b0, 5'b01000, 5'b01000, 5'b11010, 5'b00000};
    vecs[9]  = '{1'b0, 5'b01000, 5'b01010, 5'b11010, 5'b00000};
    vecs[10] = '{1'b0, 5'b01000, 5'b01010, 5'b11010, 5'b00000};
    vecs[11] = '{1'b0, 5'b01000, 5'b01010, 5'b11010, 5'b00000};
    vecs[12] = '{1'b0, 5'b01000, 5'b01010, 5'b11000, 5'b00000};
    vecs[13] = '{1'b0, 5'b01000, 5'b01010, 5'b11000, 5'b00000};
    vecs[14] = '{1'b0, 5'b01000, 5'b00010, 5'b11000, 5'b00000};
    vecs[15] = '{1'b0, 5'b01000, 5'b00010, 5'b11000, 5'b00000};
    vecs[16] = '{1'b0, 5'b01000, 5'b10010, 5'b11000, 5'b00000};
    vecs[17] = '{1'b0, 5'b01000, 5'b00010, 5'b01000, 5'b00000};
    vecs[18] = '{1'b0, 5'b01000, 5'b00010, 5'b01000, 5'b00000};

    for (int r = 0; r < 19; r++) begin
      tick(vecs[r].raw, vecs[r].green, vecs[r].rst);
      check($sformatf("table_sens_row%0d", r), sens_vec(), vecs[r].exp_sens);
      check($sformatf("table_stuck_row%0d", r), bus.stuck, vecs[r].exp_stuck);
    end

    // Lane 2 held high: latched after edge 5, stuck when run hits 200 at edge 202,
    // one low raw sample at 211 reaches the channel at edge 213, then re-debounce.
    tick(5'b00000, 5'b00000, 1'b1);
    for (int e = 1; e <= 216; e++) begin
      tick((e == 211) ? 5'b00000 : 5'b00100, 5'b00000, 1'b0);
      if (e == 5)   check("stuck_latched_e5", sens_vec(), 5'b00100);
      if (e == 201) begin
        check("stuck_pre_sens_e201", sens_vec(), 5'b00100);
        check("stuck_pre_flag_e201", bus.stuck, 5'b00000);
      end
      if (e == 202) begin
        check("stuck_sens_e202", sens_vec(), 5'b00000);
        check("stuck_flag_e202", bus.stuck, 5'b00100);
      end
      if (e == 212) check("stuck_hold_e212", bus.stuck, 5'b00100);
      if (e == 213) begin
        check("stuck_clear_flag_e213", bus.stuck, 5'b00000);
        check("stuck_clear_sens_e213", sens_vec(), 5'b00000);
      end
      if (e == 215) check("stuck_requal_e215", sens_vec(), 5'b00000);
      if (e == 216) check("stuck_relatch_e216", sens_vec(), 5'b00100);
    end

    // All lanes high, reset pulsed at edge 4 while qualifying; full debounce needed after.
    tick(5'b00000, 5'b00000, 1'b1);
    for (int e = 1; e <= 9; e++) begin
      tick(5'b11111, 5'b00000, (e == 4));
      if (e == 3) check("rst_qual_e3", sens_vec(), 5'b00000);
      if (e == 4) begin
        check("rst_sens_e4", sens_vec(), 5'b00000);
        check("rst_stuck_e4", bus.stuck, 5'b00000);
      end
      if (e == 8) check("rst_redebounce_e8", sens_vec(), 5'b00000);
      if (e == 9) check("rst_relatch_e9", sens_vec(), 5'b11111);
    end

    // Reset while latched drops the pending request immediately.
    tick(5'b11111, 5'b00000, 1'b1);
    check("rst_latched_drop", sens_vec(), 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
